// File: rtl/axis_video_out_port.sv
// axis_video_out_port: pulls pixels from an upstream read FIFO (1-cycle read
// latency) into a small output buffer and presents them as an AXI4-Stream
// video stream. tuser/tlast come from internal pixel/line counters and are
// stored alongside each word, so the output tagging is independent of the
// upstream timing. Frame/line/end alignment pulses are issued to the DMA.
module axis_video_out_port #(
    parameter int    DSIZE      = 24,
    parameter int    DEPTH      = 16,
    parameter string MODE       = "ONCE",
    parameter string FRAME_SYNC = "ON"
) (
    input  logic             i_clock,
    input  logic             i_rst,
    input  logic [15:0]      i_hactive,
    input  logic [15:0]      i_vactive,
    input  logic             i_in_vsync,
    input  logic             i_src_empty,
    output logic             o_rd_en,
    input  logic [DSIZE-1:0] i_in_data,
    output logic [DSIZE-1:0] o_axi_tdata,
    output logic             o_axi_tvalid,
    input  logic             i_axi_tready,
    output logic             o_axi_tuser,
    output logic             o_axi_tlast,
    output logic             o_axi_fsync,
    output logic             o_falign,
    output logic             o_lalign,
    output logic             o_ealign,
    output logic             o_frame_err
);

    localparam int AW        = $clog2(DEPTH);
    localparam int EW        = DSIZE + 2;
    localparam bit LINE_MODE = (MODE == "LINE");
    localparam bit SYNC_ON   = (FRAME_SYNC != "OFF");

    typedef enum logic [1:0] {S_IDLE, S_START, S_ACTIVE, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_vsync_d;
    logic            r_vsync_rise;
    logic [15:0]     r_hact;
    logic [15:0]     r_vact;
    logic [15:0]     r_pix;
    logic [15:0]     r_line;
    logic            r_inflight;
    logic [1:0]      r_tag;
    logic            r_lalign;
    logic [AW:0]     r_count;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [EW-1:0]   r_mem [DEPTH];

    logic            w_abort;
    logic            w_last_pix;
    logic            w_last_line;
    logic            w_tuser;
    logic            w_rd_en;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [AW+1:0]   w_occupancy;
    logic [EW-1:0]   w_head;

    // Early vsync only aborts a frame when frames are vsync-locked.
    assign w_abort     = SYNC_ON && (r_state == S_ACTIVE) && r_vsync_rise;
    assign w_last_pix  = (r_pix == r_hact - 16'd1);
    assign w_last_line = (r_line == r_vact - 16'd1);
    assign w_tuser     = (r_pix == 16'd0) && (r_line == 16'd0);
    // Buffered plus in-flight words must leave room for the word being requested.
    assign w_occupancy = {1'b0, r_count} + (AW + 2)'(r_inflight);
    assign w_rd_en     = (r_state == S_ACTIVE) && !w_abort && !i_src_empty &&
                         (w_occupancy < (AW + 2)'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = r_inflight;
    assign w_pop       = !w_empty && i_axi_tready;
    assign w_head      = r_mem[r_rptr];

    assign o_rd_en      = w_rd_en;
    assign o_axi_tvalid = !w_empty;
    // Head entry is gated so nothing stale or uninitialised leaks out while idle.
    assign o_axi_tdata  = w_empty ? '0 : w_head[DSIZE-1:0];
    assign o_axi_tlast  = !w_empty && w_head[DSIZE];
    assign o_axi_tuser  = !w_empty && w_head[DSIZE+1];
    assign o_falign     = (r_state == S_START);
    assign o_axi_fsync  = (r_state == S_START);
    assign o_ealign     = (r_state == S_DONE);
    assign o_frame_err  = w_abort;
    assign o_lalign     = r_lalign;

    // Registered vsync rising-edge detector.
    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            r_vsync_d    <= 1'b0;
            r_vsync_rise <= 1'b0;
        end else begin
            r_vsync_d    <= i_in_vsync;
            r_vsync_rise <= i_in_vsync && !r_vsync_d;
        end
    end

    // Frame sequencer state register.
    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Frame sequencer next state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (!SYNC_ON || r_vsync_rise) w_state_next = S_START;
            S_START:  if (i_hactive == 16'd0 || i_vactive == 16'd0) w_state_next = S_DONE;
                      else w_state_next = S_ACTIVE;
            S_ACTIVE: if (w_abort) w_state_next = S_START;
                      else if (w_rd_en && w_last_pix && w_last_line) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Geometry latch and pixel/line read counters.
    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            r_hact <= '0;
            r_vact <= '0;
            r_pix  <= '0;
            r_line <= '0;
        end else if (r_state == S_START) begin
            r_hact <= i_hactive;
            r_vact <= i_vactive;
            r_pix  <= '0;
            r_line <= '0;
        end else if (w_rd_en) begin
            if (w_last_pix) begin
                r_pix  <= '0;
                r_line <= r_line + 16'd1;
            end else begin
                r_pix <= r_pix + 16'd1;
            end
        end
    end

    // Read pipeline: tags travel with the request until the data arrives.
    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            r_inflight <= 1'b0;
            r_tag      <= '0;
            r_lalign   <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            r_tag      <= {w_tuser, w_last_pix};
            r_lalign   <= LINE_MODE && w_rd_en && w_last_pix;
        end
    end

    // Buffer storage; left unreset so it maps onto distributed RAM.
    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wptr] <= {r_tag, i_in_data};
    end

    // Buffer pointers and occupancy.
    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
